// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown driven by a slow tick wave sampled in the
// CLK domain. Holds BCD digits, a four-state run/pause/expired FSM, a one-cycle
// DONE pulse on reaching 00:00, and a level ALARM while expired.
module countdown_timer #(
  parameter int unsigned MAX_MIN = 99
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK_IN,
  input  logic       START,
  input  logic       STOP,
  input  logic       LOAD,
  input  logic [6:0] SET_MIN,
  input  logic [5:0] SET_SEC,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_O,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_O,
  output logic [1:0] STATE,
  output logic       DONE,
  output logic       ALARM
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_EXPIRED = 2'b11
  } state_e;

  localparam logic [6:0] MAX_MIN_C = 7'(MAX_MIN);

  state_e     state_q, state_d;
  logic [3:0] min_t_q, min_t_d;
  logic [3:0] min_o_q, min_o_d;
  logic [3:0] sec_t_q, sec_t_d;
  logic [3:0] sec_o_q, sec_o_d;
  logic       done_q, done_d;
  logic       alarm_q, alarm_d;
  logic       tick_dly_q, tick_dly_d;
  logic       tick;

  // Clamped load values split into BCD digits
  logic [6:0] ld_min;
  logic [5:0] ld_sec;
  logic [3:0] ld_min_t, ld_min_o, ld_sec_t, ld_sec_o;

  // Decremented count (one second less than the current digits)
  logic [3:0] dec_min_t, dec_min_o, dec_sec_t, dec_sec_o;
  logic       cnt_zero;
  logic       cnt_one;

  // Rising-edge detect of the slow wave; it is only ever used as an enable
  always_comb begin
    tick_dly_d = TICK_IN;
    tick       = TICK_IN & ~tick_dly_q;
  end

  // Clamp the requested load and convert binary to BCD digits
  always_comb begin
    ld_min   = (SET_MIN > MAX_MIN_C) ? MAX_MIN_C : SET_MIN;
    ld_sec   = (SET_SEC > 6'd59) ? 6'd59 : SET_SEC;
    ld_min_t = 4'(ld_min / 7'd10);
    ld_min_o = 4'(ld_min % 7'd10);
    ld_sec_t = 4'(ld_sec / 6'd10);
    ld_sec_o = 4'(ld_sec % 6'd10);
  end

  // Zero / one-second detection on the live count
  always_comb begin
    cnt_zero = ({min_t_q, min_o_q, sec_t_q, sec_o_q} == 16'h0000);
    cnt_one  = ({min_t_q, min_o_q, sec_t_q, sec_o_q} == 16'h0001);
  end

  // BCD borrow chain: seconds ones -> seconds tens -> minutes ones -> tens
  always_comb begin
    dec_min_t = min_t_q;
    dec_min_o = min_o_q;
    dec_sec_t = sec_t_q;
    dec_sec_o = sec_o_q;
    if (sec_o_q != 4'd0) begin
      dec_sec_o = sec_o_q - 4'd1;
    end else begin
      dec_sec_o = 4'd9;
      if (sec_t_q != 4'd0) begin
        dec_sec_t = sec_t_q - 4'd1;
      end else begin
        dec_sec_t = 4'd5;
        if (min_o_q != 4'd0) begin
          dec_min_o = min_o_q - 4'd1;
        end else begin
          dec_min_o = 4'd9;
          dec_min_t = min_t_q - 4'd1;
        end
      end
    end
  end

  // Next-state, next-count and flag logic; STOP > START > LOAD > tick
  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_o_d = min_o_q;
    sec_t_d = sec_t_q;
    sec_o_d = sec_o_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (STOP) begin
          {min_t_d, min_o_d, sec_t_d, sec_o_d} = '0;
        end else if (START && !cnt_zero) begin
          state_d = ST_RUN;
        end else if (LOAD) begin
          min_t_d = ld_min_t;
          min_o_d = ld_min_o;
          sec_t_d = ld_sec_t;
          sec_o_d = ld_sec_o;
        end
      end

      ST_RUN: begin
        if (STOP) begin
          state_d = ST_PAUSE;
        end else if (tick && !cnt_zero) begin
          min_t_d = dec_min_t;
          min_o_d = dec_min_o;
          sec_t_d = dec_sec_t;
          sec_o_d = dec_sec_o;
          if (cnt_one) begin
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
          end
        end
      end

      ST_PAUSE: begin
        if (STOP) begin
          state_d = ST_IDLE;
          {min_t_d, min_o_d, sec_t_d, sec_o_d} = '0;
        end else if (START) begin
          state_d = ST_RUN;
        end
      end

      ST_EXPIRED: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (LOAD) begin
          state_d = ST_IDLE;
          min_t_d = ld_min_t;
          min_o_d = ld_min_o;
          sec_t_d = ld_sec_t;
          sec_o_d = ld_sec_o;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    alarm_d = (state_d == ST_EXPIRED);
  end

  // State, count and flag registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      min_t_q    <= '0;
      min_o_q    <= '0;
      sec_t_q    <= '0;
      sec_o_q    <= '0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      tick_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_t_q    <= min_t_d;
      min_o_q    <= min_o_d;
      sec_t_q    <= sec_t_d;
      sec_o_q    <= sec_o_d;
      done_q     <= done_d;
      alarm_q    <= alarm_d;
      tick_dly_q <= tick_dly_d;
    end
  end

  // Registered outputs
  always_comb begin
    MIN_T = min_t_q;
    MIN_O = min_o_q;
    SEC_T = sec_t_q;
    SEC_O = sec_o_q;
    STATE = state_q;
    DONE  = done_q;
    ALARM = alarm_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes expected outputs into
// a queue, a negedge monitor pops and compares them against the DUT.
module tb_countdown_timer;

  logic       CLK;
  logic       RST;
  logic       TICK_IN;
  logic       START;
  logic       STOP;
  logic       LOAD;
  logic [6:0] SET_MIN;
  logic [5:0] SET_SEC;
  logic [3:0] MIN_T, MIN_O, SEC_T, SEC_O;
  logic [1:0] STATE;
  logic       DONE;
  logic       ALARM;

  typedef struct {
    string      name;
    logic [19:0] vec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  countdown_timer #(.MAX_MIN(99)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .TICK_IN(TICK_IN),
    .START  (START),
    .STOP   (STOP),
    .LOAD   (LOAD),
    .SET_MIN(SET_MIN),
    .SET_SEC(SET_SEC),
    .MIN_T  (MIN_T),
    .MIN_O  (MIN_O),
    .SEC_T  (SEC_T),
    .SEC_O  (SEC_O),
    .STATE  (STATE),
    .DONE   (DONE),
    .ALARM  (ALARM)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Monitor: compare every queued expectation against the outputs on negedge
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [19:0] act;
      e   = q.pop_front();
      act = {MIN_T, MIN_O, SEC_T, SEC_O, STATE, DONE, ALARM};
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL %s: got mm:ss=%h%h:%h%h st=%b done=%b alarm=%b, want mm:ss=%h%h:%h%h st=%b done=%b alarm=%b",
                 e.name, act[19:16], act[15:12], act[11:8], act[7:4], act[3:2], act[1], act[0],
                 e.vec[19:16], e.vec[15:12], e.vec[11:8], e.vec[7:4], e.vec[3:2], e.vec[1], e.vec[0]);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string nm, input int m, input int s,
                            input logic [1:0] st, input logic dn, input logic al);
    exp_t e;
    e.name = nm;
    e.vec  = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), st, dn, al};
    q.push_back(e);
  endtask

  task automatic pulse_load(input int m, input int s);
    SET_MIN = 7'(m);
    SET_SEC = 6'(s);
    LOAD = 1'b1; step(); LOAD = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1; step(); START = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP = 1'b1; step(); STOP = 1'b0;
  endtask

  task automatic tick_pulse();
    TICK_IN = 1'b1; step(); TICK_IN = 1'b0; step();
  endtask

  initial begin
    int r;
    RST = 1'b1; TICK_IN = 1'b0; START = 1'b0; STOP = 1'b0; LOAD = 1'b0;
    SET_MIN = '0; SET_SEC = '0;
    step();
    expect_out("reset", 0, 0, 2'b00, 1'b0, 1'b0);
    step();
    RST = 1'b0;
    step();

    // 1: 01:02 counted to expiry
    pulse_load(1, 2);
    expect_out("t1_load", 1, 2, 2'b00, 1'b0, 1'b0);
    pulse_start();
    expect_out("t1_start", 1, 2, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 62; i++) begin
      TICK_IN = 1'b1; step();
      r = 62 - i;
      expect_out("t1_tick", r / 60, r % 60, (r == 0) ? 2'b11 : 2'b01, (r == 0), (r == 0));
      TICK_IN = 1'b0; step();
      expect_out("t1_after", r / 60, r % 60, (r == 0) ? 2'b11 : 2'b01, 1'b0, (r == 0));
    end
    tick_pulse();
    expect_out("t1_extra_tick", 0, 0, 2'b11, 1'b0, 1'b1);

    // 2: clamp and full borrow chain
    pulse_stop();
    expect_out("t2_ack", 0, 0, 2'b00, 1'b0, 1'b0);
    pulse_load(120, 63);
    expect_out("t2_clamp", 99, 59, 2'b00, 1'b0, 1'b0);
    pulse_load(10, 0);
    expect_out("t2_load10", 10, 0, 2'b00, 1'b0, 1'b0);
    pulse_start();
    tick_pulse();
    expect_out("t2_borrow", 9, 59, 2'b01, 1'b0, 1'b0);

    // 3: pause, resume and clear
    pulse_stop();
    pulse_stop();
    expect_out("t3_cleared_pre", 0, 0, 2'b00, 1'b0, 1'b0);
    pulse_load(0, 30);
    pulse_start();
    pulse_stop();
    expect_out("t3_pause", 0, 30, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick_pulse();
    expect_out("t3_pause_hold", 0, 30, 2'b10, 1'b0, 1'b0);
    pulse_start();
    expect_out("t3_resume", 0, 30, 2'b01, 1'b0, 1'b0);
    tick_pulse();
    expect_out("t3_tick", 0, 29, 2'b01, 1'b0, 1'b0);
    pulse_stop();
    pulse_stop();
    expect_out("t3_clear", 0, 0, 2'b00, 1'b0, 1'b0);

    // 4a: START+STOP in IDLE
    pulse_load(0, 10);
    START = 1'b1; STOP = 1'b1; step(); START = 1'b0; STOP = 1'b0;
    expect_out("t4_stop_wins", 0, 0, 2'b00, 1'b0, 1'b0);
    // 4b: tick with STOP in RUN
    pulse_load(0, 10);
    pulse_start();
    TICK_IN = 1'b1; STOP = 1'b1; step(); STOP = 1'b0; TICK_IN = 1'b0; step();
    expect_out("t4_tick_stop", 0, 10, 2'b10, 1'b0, 1'b0);
    pulse_stop();
    // 4c: START with tick from IDLE drops the tick
    pulse_load(0, 10);
    TICK_IN = 1'b1; START = 1'b1; step(); START = 1'b0; TICK_IN = 1'b0; step();
    expect_out("t4_start_tick", 0, 10, 2'b01, 1'b0, 1'b0);
    tick_pulse();
    expect_out("t4_next_tick", 0, 9, 2'b01, 1'b0, 1'b0);

    // 5: ignored commands
    pulse_stop();
    pulse_stop();
    pulse_start();
    expect_out("t5_start_zero", 0, 0, 2'b00, 1'b0, 1'b0);
    pulse_load(0, 20);
    pulse_start();
    pulse_load(5, 5);
    expect_out("t5_load_in_run", 0, 20, 2'b01, 1'b0, 1'b0);
    TICK_IN = 1'b1;
    repeat (10) step();
    expect_out("t5_tick_held", 0, 19, 2'b01, 1'b0, 1'b0);
    TICK_IN = 1'b0; step();

    // 6: async reset between edges while running
    pulse_stop();
    pulse_stop();
    pulse_load(0, 45);
    pulse_start();
    expect_out("t6_run", 0, 45, 2'b01, 1'b0, 1'b0);
    step();
    #2 RST = 1'b1;
    expect_out("t6_async_rst", 0, 0, 2'b00, 1'b0, 1'b0);
    @(negedge CLK);
    #1 RST = 1'b0;
    step();
    expect_out("t6_after_rst", 0, 0, 2'b00, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    repeat (3) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Consumes the slow square wave produced by the frequency divider (about 1 Hz at the 50 MHz board clock).
- Counts a user-loaded mm:ss value down to 00:00 and drives BCD digits to the 7-segment display stage.
- Runs entirely in the CLK domain. The slow wave is treated as a tick enable via rising-edge detection and is never used as a clock.

Parameters:
MAX_MIN, 99, upper clamp for loaded minutes (binary, must be ≤ 99)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
TICK_IN  input  1  divider CLKOUT, synchronous to CLK
START  input  1  one-CLK pulse; start or resume
STOP  input  1  one-CLK pulse; pause, clear, or acknowledge
LOAD  input  1  one-CLK pulse; load SET_MIN/SET_SEC
SET_MIN  input  7  minutes to load, binary
SET_SEC  input  6  seconds to load, binary
MIN_T  output  4  minutes tens, BCD
MIN_O  output  4  minutes ones, BCD
SEC_T  output  4  seconds tens, BCD (0..5)
SEC_O  output  4  seconds ones, BCD
STATE  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED
DONE  output  1  one-CLK pulse on reaching 00:00
ALARM  output  1  high while in EXPIRED

Behaviour:
- Reset (async, RST=1): all digits 0, STATE=IDLE, DONE=0, ALARM=0, tick_d=0. Reset takes effect immediately in any state, including mid-RUN.
- Tick detection: tick_d <= TICK_IN; tick = TICK_IN & ~tick_d. Exactly one tick per TICK_IN rising edge. Falling edges are ignored.
- All outputs are registered. DONE defaults to 0 every cycle.
- Command priority within a cycle: STOP > START > LOAD. A tick is processed only in RUN, and only if no command acts in that cycle.
- IDLE:
  - LOAD converts to BCD with clamps: min = min(SET_MIN, MAX_MIN), sec = min(SET_SEC, 59). Digits are updated next cycle; state stays IDLE.
  - START with count ≠ 00:00 goes to RUN. START with count = 00:00 is ignored.
  - STOP clears the digits to 00:00.
- RUN:
  - STOP goes to PAUSE and holds the count.
  - On tick, the count decrements by one second:
    - SEC_O 0→9 borrows into SEC_T.
    - SEC_T 0→5 borrows into MIN_O.
    - MIN_O 0→9 borrows into MIN_T.
    - MIN_T decrements.
  - A tick at 00:01 yields 00:00, STATE=EXPIRED, DONE=1 for that single cycle, and ALARM=1.
  - LOAD and START are ignored in RUN.
  - The first decrement occurs on the first tick strictly after the cycle RUN is entered. A tick in the same cycle as the START that enters RUN is dropped.
- PAUSE:
  - START returns to RUN.
  - STOP clears the digits to 00:00 and goes to IDLE.
  - Ticks and LOAD are ignored.
- EXPIRED:
  - Digits stay 00:00 and ALARM stays 1.
  - STOP goes to IDLE and clears ALARM.
  - LOAD performs the load, goes to IDLE, and clears ALARM.
  - START and ticks are ignored.
- No wrap-around: the count never decrements below 00:00.

Test Plan:
1. Countdown to expiry: RST pulse, LOAD SET_MIN=1, SET_SEC=2, START, then 62 TICK_IN rising edges.
   - Required: digits read 01:02 → 01:01 → … → 00:59 → … → 00:00.
   - Required: DONE high exactly 1 CLK, STATE=11, ALARM=1.
   - Required: an extra tick leaves 00:00.
2. Clamp and borrow chain: LOAD SET_MIN=120, SET_SEC=63 → 99:59. Then LOAD SET_MIN=10, SET_SEC=0, START, one tick → 09:59.
3. Pause and clear: RUN at 00:30, STOP, five ticks → 00:30 held, STATE=10. START, one tick → 00:29. STOP, STOP → 00:00, STATE=00.
4. Simultaneous events:
   - START and STOP in the same cycle in IDLE with 00:10 → STOP wins; count cleared, stays IDLE.
   - Tick coincident with STOP in RUN at 00:10 → PAUSE at 00:10.
   - START from IDLE coincident with a tick at 00:10 → RUN, count still 00:10.
5. Ignored commands: START in IDLE at 00:00 → stays IDLE. LOAD in RUN → count unchanged. TICK_IN held high many cycles → only one decrement.
6. Async reset mid-RUN: assert RST between CLK edges at 00:45 → outputs clear before the next CLK edge, STATE=00, ALARM=0.
